seu_error_record_buffer: RTL

SEU_ERROR_RECORD_BUFFER -- requirements
Module: seu_error_record_buffer

---
 rtl/seu_error_record_buffer_pkg.sv | 15 +
 rtl/seu_rec_fifo.sv | 68 ++++++
 rtl/seu_error_record_buffer.sv | 116 +++++++++++
 3 files changed

// File: rtl/seu_error_record_buffer_pkg.sv
// Shared types and sizes for the SEU error record buffer.
// Holds record/word widths, default FIFO depth and the serializer state enum.
package seu_pkg;

    localparam int REC_W         = 128;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_REC = 4;
    localparam int DEPTH_DEF     = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/seu_rec_fifo.sv
// Single-clock record FIFO, REC_W bits wide, synchronous active-high reset.
// Ports: wr_en/wr_data push, rd_en pops head, count/full/empty status.
module seu_rec_fifo
    import seu_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [REC_W-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [REC_W-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Power-of-two depth: pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/seu_error_record_buffer.sv
// Captures flagged 128-bit checker records into a FIFO and streams each as 4x32-bit words.
// Ports: capture_en/rec_in in, word_out/valid/ready/last stream out, fifo_count, drop_count.
module seu_error_record_buffer
    import seu_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   capture_en,
    input  logic [REC_W-1:0]       rec_in,
    input  logic                   clear_drop,
    output logic [WORD_W-1:0]      word_out,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic                   word_last,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            drop_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    ser_state_e       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      drop_count_q, drop_count_d;

    logic             capture;
    logic             xfer;
    logic             pop;
    logic             wr_en;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] head;

    assign capture = capture_en & rec_in[REC_W-1];
    assign xfer    = (state_q == ST_SEND) & word_ready;
    assign pop     = xfer & (idx_q == 2'd3);
    // A full FIFO still accepts when the head leaves on the same edge.
    assign wr_en   = capture & (~fifo_full | pop);

    seu_rec_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_data(rec_in),
        .rd_en  (pop),
        .head   (head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_SEND;
                    idx_d   = 2'd0;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    idx_d = idx_q + 2'd1;
                    // Last record leaving with nothing arriving behind it.
                    if (pop && fifo_count == CW'(1) && !wr_en) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        drop_count_d = drop_count_q;
        if (clear_drop) begin
            drop_count_d = '0;
        end else if (capture && fifo_full && !pop
                     && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Outputs decode registered state and the registered FIFO head only.
    always_comb begin
        word_out = '0;
        if (state_q == ST_SEND) begin
            unique case (idx_q)
                2'd0: word_out = head[127:96];
                2'd1: word_out = head[95:64];
                2'd2: word_out = head[63:32];
                2'd3: word_out = head[31:0];
            endcase
        end
    end

    assign word_valid = (state_q == ST_SEND);
    assign word_last  = (state_q == ST_SEND) & (idx_q == 2'd3);
    assign drop_count = drop_count_q;

endmodule
